// File: rtl/sparc_ifu_thrsched.sv
// sparc_ifu_thrsched: round-robin IFU thread scheduler with a run quantum.
// Rev 1.0
`default_nettype none

module sparc_ifu_thrsched #(
  parameter int NTHR    = 4,
  parameter int QUANTUM = 16,
  parameter int QW      = 5
) (
  input  logic                    clk,
  input  logic                    arst_l,
  input  logic                    sched_en,
  input  logic                    pipe_hold,
  input  logic [NTHR-1:0]         thr_rdy,
  input  logic [NTHR-1:0]         thr_spec_rdy,
  input  logic [NTHR-1:0]         thr_leave,
  output logic [NTHR-1:0]         schedule,
  output logic                    switch_out,
  output logic [NTHR-1:0]         thr_active,
  output logic                    sched_valid,
  output logic [$clog2(NTHR)-1:0] rr_ptr
);

  localparam int PW = $clog2(NTHR);
  localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SWITCH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NTHR-1:0] thr_active_q, thr_active_d;
  logic [NTHR-1:0] schedule_q, schedule_d;
  logic            switch_out_q, switch_out_d;
  logic            sched_valid_q, sched_valid_d;

  logic [NTHR-1:0] rdy_m, spec_m, pool, cand_oh;
  logic [PW-1:0]   cand_idx, idx;
  logic            cand_vld;
  logic            leave_act;

  // The running thread never competes with itself; READY beats SPEC_READY.
  always_comb begin
    rdy_m    = thr_rdy & ~thr_active_q;
    spec_m   = thr_spec_rdy & ~thr_active_q;
    pool     = (|rdy_m) ? rdy_m : spec_m;
    cand_vld = |pool;
    cand_idx = '0;
    idx      = '0;
    // Walk from farthest to nearest so the nearest hit after rr_ptr wins.
    for (int k = NTHR; k >= 1; k--) begin
      idx = PW'((int'(rr_ptr_q) + k) % NTHR);
      if (pool[idx]) cand_idx = idx;
    end
    cand_oh   = {{(NTHR-1){1'b0}}, 1'b1} << cand_idx;
    leave_act = |(thr_leave & thr_active_q);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    thr_active_d = thr_active_q;
    schedule_d   = '0;
    switch_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sched_en && !pipe_hold && cand_vld) begin
          schedule_d   = cand_oh;
          thr_active_d = cand_oh;
          rr_ptr_d     = cand_idx;
          cnt_d        = '0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        // A self-initiated leave is honoured even while the pipe is frozen.
        if (leave_act) begin
          thr_active_d = '0;
          state_d      = S_IDLE;
        end else if (!pipe_hold) begin
          if (cnt_q == QMAX && cand_vld) begin
            switch_out_d = 1'b1;
            thr_active_d = '0;
            state_d      = S_SWITCH;
          end else if (cnt_q != QMAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_SWITCH: begin
        if (!pipe_hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    sched_valid_d = |thr_active_d;
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rr_ptr_q      <= PW'(NTHR - 1);
      thr_active_q  <= '0;
      schedule_q    <= '0;
      switch_out_q  <= 1'b0;
      sched_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      thr_active_q  <= thr_active_d;
      schedule_q    <= schedule_d;
      switch_out_q  <= switch_out_d;
      sched_valid_q <= sched_valid_d;
    end
  end

  assign schedule    = schedule_q;
  assign switch_out  = switch_out_q;
  assign thr_active  = thr_active_q;
  assign sched_valid = sched_valid_q;
  assign rr_ptr      = rr_ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_sparc_ifu_thrsched.sv
// Scoreboard bench for sparc_ifu_thrsched: expected pulses queued with their edge number.
`default_nettype none

module tb_sparc_ifu_thrsched;

  logic       clk = 1'b0;
  logic       arst_l;
  logic       sched_en, pipe_hold;
  logic [3:0] thr_rdy, thr_spec_rdy, thr_leave;
  logic [3:0] schedule, thr_active;
  logic       switch_out, sched_valid;
  logic [1:0] rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s;

  typedef struct {
    bit         is_sw;
    logic [3:0] val;
    logic [1:0] rr;
    int         at;
  } ev_t;
  ev_t q[$];

  sparc_ifu_thrsched #(.NTHR(4), .QUANTUM(16), .QW(5)) dut (
    .clk         (clk),
    .arst_l      (arst_l),
    .sched_en    (sched_en),
    .pipe_hold   (pipe_hold),
    .thr_rdy     (thr_rdy),
    .thr_spec_rdy(thr_spec_rdy),
    .thr_leave   (thr_leave),
    .schedule    (schedule),
    .switch_out  (switch_out),
    .thr_active  (thr_active),
    .sched_valid (sched_valid),
    .rr_ptr      (rr_ptr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input bit is_sw, input logic [3:0] val, input logic [1:0] rr, input int at);
    ev_t e;
    e.is_sw = is_sw; e.val = val; e.rr = rr; e.at = at;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (schedule != 4'b0 || switch_out) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: schedule=%b switch_out=%b at edge %0d, none expected",
                 schedule, switch_out, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (switch_out !== e.is_sw || schedule !== e.val || cyc != e.at ||
            (!e.is_sw && rr_ptr !== e.rr)) begin
          n_fail++;
          $display("FAIL pulse: got sw=%b sched=%b rr=%0d edge=%0d, expected sw=%b sched=%b rr=%0d edge=%0d",
                   switch_out, schedule, rr_ptr, cyc, e.is_sw, e.val, e.rr, e.at);
        end
      end
    end
  end

  initial begin
    arst_l = 1'b0; sched_en = 1'b0; pipe_hold = 1'b0;
    thr_rdy = '0; thr_spec_rdy = '0; thr_leave = '0;
    tick(3);
    chk("rst_schedule", 32'(schedule), 0);
    chk("rst_switch_out", 32'(switch_out), 0);
    chk("rst_active", 32'(thr_active), 0);
    chk("rst_valid", 32'(sched_valid), 0);
    chk("rst_rr_ptr", 32'(rr_ptr), 3);

    // T1: first pick right after release
    thr_rdy = 4'b0001; sched_en = 1'b1;
    arst_l = 1'b1;
    push(0, 4'b0001, 2'd0, cyc + 1);
    tick(1); s = cyc;
    chk("t1_active", 32'(thr_active), 32'b0001);
    chk("t1_valid", 32'(sched_valid), 1);
    chk("t1_rr", 32'(rr_ptr), 0);

    // T2: quantum expiry with T2 waiting
    thr_rdy = 4'b0100;
    push(1, 4'b0000, 2'd0, s + 16);
    push(0, 4'b0100, 2'd2, s + 18);
    tick(15);
    chk("t2_still_active", 32'(thr_active), 32'b0001);
    tick(1);
    chk("t2_sw_active", 32'(thr_active), 0);
    tick(2); s = cyc;
    chk("t2_new_active", 32'(thr_active), 32'b0100);
    chk("t2_rr", 32'(rr_ptr), 2);

    // T3: SPEC_READY when no READY, then READY wins
    thr_rdy = 4'b0000; thr_spec_rdy = 4'b1000; thr_leave = 4'b0100;
    tick(1); thr_leave = '0;
    chk("t3_idle", 32'(thr_active), 0);
    push(0, 4'b1000, 2'd3, cyc + 1);
    tick(1);
    chk("t3_spec_active", 32'(thr_active), 32'b1000);
    thr_leave = 4'b1000; thr_rdy = 4'b0010;
    tick(1); thr_leave = '0;
    push(0, 4'b0010, 2'd1, cyc + 1);
    tick(1); s = cyc;
    chk("t3_rdy_active", 32'(thr_active), 32'b0010);

    // T4: leave coincides with quantum expiry
    thr_rdy = '0; thr_spec_rdy = '0;
    tick(15);
    thr_rdy = 4'b0001; thr_leave = 4'b0010;
    tick(1); thr_leave = '0;
    chk("t4_active_cleared", 32'(thr_active), 0);
    chk("t4_no_switch", 32'(switch_out), 0);
    push(0, 4'b0001, 2'd0, cyc + 1);
    tick(1); s = cyc;
    chk("t4_new_active", 32'(thr_active), 32'b0001);

    // T5: pipe_hold freezes the quantum for 10 cycles
    thr_rdy = 4'b0010;
    push(1, 4'b0000, 2'd0, s + 26);
    push(0, 4'b0010, 2'd1, s + 28);
    tick(5); pipe_hold = 1'b1;
    tick(10);
    chk("t5_hold_active", 32'(thr_active), 32'b0001);
    pipe_hold = 1'b0;
    tick(13); s = cyc;
    chk("t5_new_active", 32'(thr_active), 32'b0010);

    // T5b: leave honoured during hold; no pick while held
    pipe_hold = 1'b1; thr_leave = 4'b0010; thr_rdy = '0;
    tick(1);
    chk("t5b_leave_active", 32'(thr_active), 0);
    chk("t5b_leave_valid", 32'(sched_valid), 0);
    thr_leave = '0; thr_rdy = 4'b0001;
    tick(2);
    chk("t5b_hold_no_pick", 32'(thr_active), 0);
    pipe_hold = 1'b0;
    push(0, 4'b0001, 2'd0, cyc + 1);
    tick(1);
    chk("t5b_pick", 32'(thr_active), 32'b0001);

    // T6: async reset with switch_out pending
    thr_rdy = 4'b0100;
    tick(15);
    #2 arst_l = 1'b0; sched_en = 1'b0;
    #1;
    chk("t6_active", 32'(thr_active), 0);
    chk("t6_valid", 32'(sched_valid), 0);
    chk("t6_switch", 32'(switch_out), 0);
    chk("t6_rr", 32'(rr_ptr), 3);
    tick(2);
    arst_l = 1'b1;
    tick(3);
    chk("t6_no_pick_disabled", 32'(thr_active), 0);
    sched_en = 1'b1;
    push(0, 4'b0100, 2'd2, cyc + 1);
    tick(1);
    chk("t6_pick", 32'(thr_active), 32'b0100);

    tick(3);
    chk("sb_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
